multi_process_register_machine: RTL and testbench
=================================================

Name: multi_process_register_machine

Overview:
- Parametrised successor to the single-process generated comparison machine.
- Runs P independent processes over one shared datapath. Each process has its own instruction store, register file, program counter, stop flag and return code.
- Processes execute one instruction per clock in fixed round-robin order, so Java and RTL traces stay lock-stepped.
- Sits under the chip test harness: loaded, started and inspected through a program and debug port.

Parameters:
- W, 8, register data width in bits.
- R, 16, registers per process; RB = clog2(R).
- P, 2, number of processes; PB = clog2(P), minimum 1.
- D, 32, instruction slots per process; DB = clog2(D).
- SW, 16, width of the step counter and max_steps.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  write one instruction.
- prog_proc  in  PB  target process.
- prog_addr  in  DB  target slot.
- prog_data  in  4+3*RB+W  instruction {op[3:0], dst, a, b, imm}.
- start  in  1  single-cycle start pulse.
- max_steps  in  SW  round limit, sampled on start.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- timeout  out  1  DONE was reached by the step limit.
- step_count  out  SW  completed rounds.
- dbg_proc  in  PB  debug process select.
- dbg_reg  in  RB  debug register select.
- dbg_data  out  W  registered register value.
- dbg_pc  out  DB+1  registered pc of dbg_proc.
- dbg_stop  out  1  registered stop flag of dbg_proc.
- dbg_rc  out  W  registered return code of dbg_proc.

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; all pcs, regs, stop flags, rcs, cur, step cleared. Instruction store contents after reset are don't-care.
- FSM IDLE -> RUN on start. On entry: pcs, regs, stops and rcs cleared; step=0; cur=0; max_steps latched.
- FSM RUN -> DONE when all stop flags are set, or when a round completes with step+1==max_steps; the second case sets timeout=1. max_steps=0 goes to DONE after the first round with timeout=1.
- FSM DONE -> RUN on start, re-initialising as above.
- Program writes are accepted in IDLE and DONE only; prog_we in RUN is ignored.
- start in RUN is ignored.
- Each RUN cycle executes process cur at its pc, then cur advances cur==P-1 ? 0 : cur+1.
- When cur wraps to 0, step increments; step_count shows the new value the next cycle.
- A stopped process's slot is an idle cycle (no skipping), keeping timing deterministic.
- Ops. Unless stated, pc+1 after execute.
  - 0 NOP.
  - 1 SET: dst=imm.
  - 2 MOV: dst=a.
  - 3 ADD: dst=a+b mod 2^W.
  - 4 SUB: dst=a-b mod 2^W.
  - 5..10 GE, GT, LE, LT, NE, EQ: dst = (a op b) ? 1 : 0, unsigned compare, zero-extended.
  - 11 JNZ: pc = (a!=0) ? imm[DB-1:0] : pc+1.
  - 12 JMP: pc=imm[DB-1:0].
  - 13 HALT: rc=imm, stop=1.
  - 14-15 illegal: rc=all-ones, stop=1.
- Register reads see values before this cycle's write (nonblocking semantics). dst==a is legal.
- pc reaching D sets stop; rc is unchanged. pc is DB+1 bits, so this is detectable.
- Debug outputs update one cycle after select inputs change, in every state.
- Reset mid-RUN aborts immediately to IDLE.

Decomposition:
- Package multi_process_register_machine_pkg holds:
  - opcode enum;
  - instruction struct {op, dst, a, b, imm};
  - state enum IDLE/RUN/DONE;
  - RC_ILLEGAL constant.
- Sub-module process_alu: combinational. Takes op, a, b and returns result, write-enable and compare flag.
- Top holds the FSM, scheduler, per-process state arrays and instruction store.

Test Plan:
- Comparison program on P=1: SET r0=0, SET r1=1, GE r4=r0,r1, GT, LE r6=r1,r0, LT r7=r1,r0, NE r8=r0,r0, EQ, then the mirrored six. Required: r4..r9 = 0,0,0,0,0,0 and r10..r15 = 1,1,1,1,1,1. stop is set at pc=16 after 16 rounds; timeout=0.
- P=2 interleave: proc0 runs SET r0=5 then HALT 7; proc1 runs SET r0=9, ADD r1=r0,r0, HALT 3. Required: proc0 r0=5, rc=7; proc1 r1=18, rc=3; done with step_count=3.
- Loop timeout: JMP 0 with max_steps=10. Required: done=1, timeout=1, step_count=10.
- Wrap and illegal: ADD 200+100 with W=8 gives 44. Opcode 15 gives rc=255 and stop=1.
- Write during RUN: prog_we to slot 0 mid-run. Required: program unchanged on the second start, identical results.
- Reset mid-run: reset_n low at round 3. Required: busy, done and timeout all 0 the same edge; dbg_pc=0 and dbg_data=0.

Source files
------------

// File: rtl/multi_process_register_machine_pkg.sv
// Shared types for the multi-process register machine: opcodes, FSM states,
// the default instruction layout and the illegal-opcode return code.
package multi_process_register_machine_pkg;

  localparam int W_DEF  = 8;
  localparam int R_DEF  = 16;
  localparam int RB_DEF = $clog2(R_DEF);

  localparam logic [W_DEF-1:0] RC_ILLEGAL = '1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_SET  = 4'd1,
    OP_MOV  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_GE   = 4'd5,
    OP_GT   = 4'd6,
    OP_LE   = 4'd7,
    OP_LT   = 4'd8,
    OP_NE   = 4'd9,
    OP_EQ   = 4'd10,
    OP_JNZ  = 4'd11,
    OP_JMP  = 4'd12,
    OP_HALT = 4'd13
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Instruction word {op, dst, a, b, imm} at the default register geometry.
  typedef struct packed {
    opcode_e            op;
    logic [RB_DEF-1:0]  dst;
    logic [RB_DEF-1:0]  a;
    logic [RB_DEF-1:0]  b;
    logic [W_DEF-1:0]   imm;
  } instr_t;

  // A single process still needs a one-bit select field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_process_register_machine_process_alu.sv
// Combinational datapath shared by all processes: register-writing ops only.
// SET arrives with its immediate already placed on operand b.
module process_alu
  import multi_process_register_machine_pkg::*;
#(
  parameter int W = 8
) (
  input  opcode_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         wr_en,
  output logic         cmp
);

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    result = '0;
    wr_en  = 1'b0;
    cmp    = 1'b0;
    case (op)
      OP_SET: begin result = b;     wr_en = 1'b1; end
      OP_MOV: begin result = a;     wr_en = 1'b1; end
      OP_ADD: begin result = a + b; wr_en = 1'b1; end
      OP_SUB: begin result = a - b; wr_en = 1'b1; end
      OP_GE:  begin cmp = (a >= b); result = W'(cmp); wr_en = 1'b1; end
      OP_GT:  begin cmp = (a >  b); result = W'(cmp); wr_en = 1'b1; end
      OP_LE:  begin cmp = (a <= b); result = W'(cmp); wr_en = 1'b1; end
      OP_LT:  begin cmp = (a <  b); result = W'(cmp); wr_en = 1'b1; end
      OP_NE:  begin cmp = (a != b); result = W'(cmp); wr_en = 1'b1; end
      OP_EQ:  begin cmp = (a == b); result = W'(cmp); wr_en = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_process_register_machine.sv
// P independent register-machine processes time-sharing one datapath in
// strict round-robin, one instruction per clock, with program/debug access.
module multi_process_register_machine
  import multi_process_register_machine_pkg::*;
#(
  parameter int  W  = 8,
  parameter int  R  = 16,
  parameter int  P  = 2,
  parameter int  D  = 32,
  parameter int  SW = 16,
  localparam int RB = $clog2(R),
  localparam int PB = clog2_min1(P),
  localparam int DB = $clog2(D),
  localparam int IW = 4 + 3 * RB + W
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          prog_we,
  input  logic [PB-1:0] prog_proc,
  input  logic [DB-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic [SW-1:0] max_steps,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [SW-1:0] step_count,
  input  logic [PB-1:0] dbg_proc,
  input  logic [RB-1:0] dbg_reg,
  output logic [W-1:0]  dbg_data,
  output logic [DB:0]   dbg_pc,
  output logic          dbg_stop,
  output logic [W-1:0]  dbg_rc
);

  localparam logic [PB-1:0] LAST_PROC = PB'(P - 1);
  localparam logic [DB:0]   PC_END    = (DB + 1)'(D);

  state_e        state_q;
  logic          busy_q, done_q, timeout_q;

  logic [IW-1:0] imem [P][D];

  logic [W-1:0]  regs_q [P][R];
  logic [W-1:0]  regs_d [P][R];
  logic [DB:0]   pcs_q  [P];
  logic [DB:0]   pcs_d  [P];
  logic [W-1:0]  rc_q   [P];
  logic [W-1:0]  rc_d   [P];
  logic [P-1:0]  stop_q, stop_d;
  logic [PB-1:0] cur_q, cur_d;
  logic [SW-1:0] step_q, step_d;
  logic [SW-1:0] max_q, max_d;

  logic [W-1:0]  dbg_data_q, dbg_data_d;
  logic [DB:0]   dbg_pc_q, dbg_pc_d;
  logic          dbg_stop_q, dbg_stop_d;
  logic [W-1:0]  dbg_rc_q, dbg_rc_d;

  logic [IW-1:0] instr_word;
  opcode_e       ins_op;
  logic [RB-1:0] ins_dst, ins_a, ins_b;
  logic [W-1:0]  ins_imm;
  logic [W-1:0]  ra_val, rb_val, alu_b, alu_res;
  logic          alu_wr, alu_cmp;
  logic [DB:0]   pc_plus, pc_next;
  logic          init, round_end, limit_hit, all_stop;
  logic [PB-1:0] dbg_sel;

  // Instruction fetch and field decode for the process owning this cycle.
  assign instr_word = imem[cur_q][pcs_q[cur_q][DB-1:0]];
  assign ins_op     = opcode_e'(instr_word[IW-1 -: 4]);
  assign ins_dst    = instr_word[W+3*RB-1 -: RB];
  assign ins_a      = instr_word[W+2*RB-1 -: RB];
  assign ins_b      = instr_word[W+RB-1 -: RB];
  assign ins_imm    = instr_word[W-1:0];

  assign ra_val  = regs_q[cur_q][ins_a];
  assign rb_val  = regs_q[cur_q][ins_b];
  assign alu_b   = (ins_op == OP_SET) ? ins_imm : rb_val;
  assign pc_plus = pcs_q[cur_q] + (DB + 1)'(1);

  process_alu #(.W(W)) u_alu (
    .op     (ins_op),
    .a      (ra_val),
    .b      (alu_b),
    .result (alu_res),
    .wr_en  (alu_wr),
    .cmp    (alu_cmp)
  );

  assign init      = start && (state_q != ST_RUN);
  assign round_end = (state_q == ST_RUN) && (cur_q == LAST_PROC);

  always_comb begin
    regs_d  = regs_q;
    pcs_d   = pcs_q;
    rc_d    = rc_q;
    stop_d  = stop_q;
    cur_d   = cur_q;
    step_d  = step_q;
    max_d   = max_q;
    pc_next = pc_plus;
    if (init) begin
      for (int p = 0; p < P; p++) begin
        pcs_d[p] = '0;
        rc_d[p]  = '0;
        for (int r = 0; r < R; r++) regs_d[p][r] = '0;
      end
      stop_d = '0;
      cur_d  = '0;
      step_d = '0;
      max_d  = max_steps;
    end else if (state_q == ST_RUN) begin
      // A stopped process still consumes its slot so the schedule never shifts.
      if (!stop_q[cur_q]) begin
        if (alu_wr) regs_d[cur_q][ins_dst] = alu_res;
        case (ins_op)
          OP_NOP, OP_SET, OP_MOV, OP_ADD, OP_SUB,
          OP_GE, OP_GT, OP_LE, OP_LT, OP_NE, OP_EQ: ;
          OP_JNZ:  if (ra_val != '0) pc_next = {1'b0, ins_imm[DB-1:0]};
          OP_JMP:  pc_next = {1'b0, ins_imm[DB-1:0]};
          OP_HALT: begin rc_d[cur_q] = ins_imm; stop_d[cur_q] = 1'b1; end
          default: begin rc_d[cur_q] = '1;      stop_d[cur_q] = 1'b1; end
        endcase
        pcs_d[cur_q] = pc_next;
        if (pc_next == PC_END) stop_d[cur_q] = 1'b1;
      end
      cur_d = (cur_q == LAST_PROC) ? '0 : cur_q + PB'(1);
      if (round_end) step_d = step_q + SW'(1);
    end
  end

  assign all_stop  = &stop_d;
  assign limit_hit = round_end && ((max_q == '0) || (step_d == max_q));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (all_stop || limit_hit) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= !all_stop;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the instruction store has no reset; its contents are only meaningful once loaded.
  always_ff @(posedge clock) begin
    if (prog_we && (state_q != ST_RUN) && (prog_proc <= LAST_PROC))
      imem[prog_proc][prog_addr] <= prog_data;
  end

  assign dbg_sel = (dbg_proc > LAST_PROC) ? '0 : dbg_proc;

  always_comb begin
    dbg_data_d = regs_q[dbg_sel][dbg_reg];
    dbg_pc_d   = pcs_q[dbg_sel];
    dbg_stop_d = stop_q[dbg_sel];
    dbg_rc_d   = rc_q[dbg_sel];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < P; p++) begin
        pcs_q[p] <= '0;
        rc_q[p]  <= '0;
        for (int r = 0; r < R; r++) regs_q[p][r] <= '0;
      end
      stop_q     <= '0;
      cur_q      <= '0;
      step_q     <= '0;
      max_q      <= '0;
      dbg_data_q <= '0;
      dbg_pc_q   <= '0;
      dbg_stop_q <= 1'b0;
      dbg_rc_q   <= '0;
    end else begin
      regs_q     <= regs_d;
      pcs_q      <= pcs_d;
      rc_q       <= rc_d;
      stop_q     <= stop_d;
      cur_q      <= cur_d;
      step_q     <= step_d;
      max_q      <= max_d;
      dbg_data_q <= dbg_data_d;
      dbg_pc_q   <= dbg_pc_d;
      dbg_stop_q <= dbg_stop_d;
      dbg_rc_q   <= dbg_rc_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign step_count = step_q;
  assign dbg_data   = dbg_data_q;
  assign dbg_pc     = dbg_pc_q;
  assign dbg_stop   = dbg_stop_q;
  assign dbg_rc     = dbg_rc_q;

endmodule

// File: tb/tb_multi_process_register_machine.sv
// Directed bench: a two-process machine for scheduling, limits and debug, and
// a one-process, 16-slot machine for the comparison program.
module tb_multi_process_register_machine;
  import multi_process_register_machine_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        prog_we = 1'b0;
  logic        prog_proc = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [23:0] prog_data = '0;
  logic        start2 = 1'b0, start1 = 1'b0;
  logic [15:0] max_steps = '0;
  logic        dbg_proc = 1'b0;
  logic [3:0]  dbg_reg = '0;

  logic        busy2, done2, timeout2, stop2;
  logic [15:0] step2;
  logic [7:0]  data2, rc2;
  logic [5:0]  pc2;

  logic        busy1, done1, timeout1, stop1;
  logic [15:0] step1;
  logic [7:0]  data1, rc1;
  logic [4:0]  pc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multi_process_register_machine dut (
    .clock(clock), .reset_n(reset_n),
    .prog_we(prog_we), .prog_proc(prog_proc), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start2), .max_steps(max_steps),
    .busy(busy2), .done(done2), .timeout(timeout2), .step_count(step2),
    .dbg_proc(dbg_proc), .dbg_reg(dbg_reg),
    .dbg_data(data2), .dbg_pc(pc2), .dbg_stop(stop2), .dbg_rc(rc2)
  );

  multi_process_register_machine #(.P(1), .D(16)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .prog_we(prog_we), .prog_proc(prog_proc), .prog_addr(prog_addr[3:0]), .prog_data(prog_data),
    .start(start1), .max_steps(max_steps),
    .busy(busy1), .done(done1), .timeout(timeout1), .step_count(step1),
    .dbg_proc(dbg_proc), .dbg_reg(dbg_reg),
    .dbg_data(data1), .dbg_pc(pc1), .dbg_stop(stop1), .dbg_rc(rc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ins(input opcode_e op, input int d, input int a,
                                      input int b, input int imm);
    instr_t t;
    t.op  = op;
    t.dst = 4'(d);
    t.a   = 4'(a);
    t.b   = 4'(b);
    t.imm = 8'(imm);
    return t;
  endfunction

  task automatic load(input int p, input int addr, input logic [23:0] w);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_proc = 1'(p);
    prog_addr = 5'(addr);
    prog_data = w;
    @(negedge clock);
    prog_we   = 1'b0;
  endtask

  task automatic run2(input int ms, input bit poke);
    @(negedge clock);
    max_steps = 16'(ms);
    start2    = 1'b1;
    @(negedge clock);
    start2    = 1'b0;
    if (poke) begin
      prog_we   = 1'b1;
      prog_proc = 1'b0;
      prog_addr = '0;
      prog_data = ins(OP_SET, 0, 0, 0, 77);
      @(negedge clock);
      prog_we   = 1'b0;
    end
    for (int n = 0; n < 2000 && !done2; n++) @(negedge clock);
    check("run2_done", done2, 1);
  endtask

  task automatic run1(input int ms);
    @(negedge clock);
    max_steps = 16'(ms);
    start1    = 1'b1;
    @(negedge clock);
    start1    = 1'b0;
    for (int n = 0; n < 2000 && !done1; n++) @(negedge clock);
    check("run1_done", done1, 1);
  endtask

  task automatic peek(input int p, input int r);
    @(negedge clock);
    dbg_proc = 1'(p);
    dbg_reg  = 4'(r);
    @(negedge clock);
  endtask

  initial begin
    #2;
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_timeout", timeout2, 0);
    check("rst_step", step2, 0);
    check("rst_pc", pc2, 0);
    check("rst_data", data2, 0);
    check("rst_busy1", busy1, 0);
    #10 reset_n = 1'b1;

    // Comparison program, single process, 16 slots.
    load(0, 0,  ins(OP_SET, 0, 0, 0, 0));
    load(0, 1,  ins(OP_SET, 1, 0, 0, 1));
    load(0, 2,  ins(OP_GE, 4, 0, 1, 0));
    load(0, 3,  ins(OP_GT, 5, 0, 1, 0));
    load(0, 4,  ins(OP_LE, 6, 1, 0, 0));
    load(0, 5,  ins(OP_LT, 7, 1, 0, 0));
    load(0, 6,  ins(OP_NE, 8, 0, 0, 0));
    load(0, 7,  ins(OP_EQ, 9, 0, 1, 0));
    load(0, 8,  ins(OP_GE, 10, 1, 0, 0));
    load(0, 9,  ins(OP_GT, 11, 1, 0, 0));
    load(0, 10, ins(OP_LE, 12, 0, 1, 0));
    load(0, 11, ins(OP_LT, 13, 0, 1, 0));
    load(0, 12, ins(OP_NE, 14, 0, 1, 0));
    load(0, 13, ins(OP_EQ, 15, 0, 0, 0));
    load(0, 14, ins(OP_NOP, 0, 0, 0, 0));
    load(0, 15, ins(OP_NOP, 0, 0, 0, 0));
    run1(100);
    check("cmp_step", step1, 16);
    check("cmp_timeout", timeout1, 0);
    peek(0, 0);
    check("cmp_pc", pc1, 16);
    check("cmp_stop", stop1, 1);
    for (int r = 4; r < 16; r++) begin
      peek(0, r);
      check($sformatf("cmp_r%0d", r), data1, (r >= 10) ? 1 : 0);
    end

    // Two-process interleave.
    load(0, 0, ins(OP_SET, 0, 0, 0, 5));
    load(0, 1, ins(OP_HALT, 0, 0, 0, 7));
    load(1, 0, ins(OP_SET, 0, 0, 0, 9));
    load(1, 1, ins(OP_ADD, 1, 0, 0, 0));
    load(1, 2, ins(OP_HALT, 0, 0, 0, 3));
    run2(100, 1'b0);
    check("il_step", step2, 3);
    check("il_timeout", timeout2, 0);
    check("il_busy", busy2, 0);
    peek(0, 0);
    check("il_p0_r0", data2, 5);
    check("il_p0_rc", rc2, 7);
    peek(1, 1);
    check("il_p1_r1", data2, 18);
    check("il_p1_rc", rc2, 3);
    check("il_p1_stop", stop2, 1);

    // A program write during RUN must be dropped.
    run2(100, 1'b1);
    run2(100, 1'b0);
    check("wr_step", step2, 3);
    peek(0, 0);
    check("wr_p0_r0", data2, 5);
    check("wr_p0_rc", rc2, 7);
    peek(1, 1);
    check("wr_p1_r1", data2, 18);

    // Endless loops stopped by the round limit.
    load(0, 0, ins(OP_JMP, 0, 0, 0, 0));
    load(1, 0, ins(OP_JMP, 0, 0, 0, 0));
    run2(10, 1'b0);
    check("to_timeout", timeout2, 1);
    check("to_step", step2, 10);
    run2(0, 1'b0);
    check("to0_timeout", timeout2, 1);
    check("to0_step", step2, 1);

    // Modular add and illegal opcode.
    load(0, 0, ins(OP_SET, 0, 0, 0, 200));
    load(0, 1, ins(OP_SET, 1, 0, 0, 100));
    load(0, 2, ins(OP_ADD, 2, 0, 1, 0));
    load(0, 3, ins(opcode_e'(4'd15), 0, 0, 0, 0));
    load(1, 0, ins(OP_HALT, 0, 0, 0, 0));
    run2(100, 1'b0);
    check("ill_timeout", timeout2, 0);
    peek(0, 2);
    check("wrap_r2", data2, 44);
    check("ill_rc", rc2, RC_ILLEGAL);
    check("ill_stop", stop2, 1);
    check("ill_pc", pc2, 4);

    // Reset in the middle of a run.
    load(0, 0, ins(OP_SET, 0, 0, 0, 33));
    load(0, 1, ins(OP_JMP, 0, 0, 0, 1));
    load(1, 0, ins(OP_JMP, 0, 0, 0, 0));
    peek(0, 0);
    @(negedge clock);
    max_steps = 16'd100;
    start2    = 1'b1;
    @(negedge clock);
    start2    = 1'b0;
    repeat (5) @(negedge clock);
    check("mr_busy_pre", busy2, 1);
    check("mr_data_pre", data2, 33);
    check("mr_pc_pre", pc2, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mr_busy", busy2, 0);
    check("mr_done", done2, 0);
    check("mr_timeout", timeout2, 0);
    check("mr_pc", pc2, 0);
    check("mr_data", data2, 0);
    check("mr_step", step2, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
